// File: rtl/game_multibar.sv
// Falling-bar game engine: several bars scroll toward a check row where the player column
// must sit inside the bar's hole; run/pause/over control, LFSR hole placement, speed-up.
module game_multibar #(
   parameter int unsigned NUM_BARS         = 2,
   parameter int unsigned POS_W            = 9,
   parameter int unsigned BAR_START        = 80,
   parameter int unsigned BAR_SPACING      = 256,
   parameter int unsigned SCREEN_END       = 510,
   parameter int unsigned CHECK_ROW        = 440,
   parameter int unsigned COLS             = 16,
   parameter int unsigned HOLE_W           = 3,
   parameter int unsigned HOLE_RESET       = 7,
   parameter int unsigned LIFE_W           = 2,
   parameter int unsigned LIVES_INIT       = 3,
   parameter int unsigned CYCLES_INIT      = 7,
   parameter int unsigned CYCLES_MIN       = 1,
   parameter int unsigned ROUNDS_PER_LEVEL = 3,
   parameter int unsigned TIME_W           = 16,
   parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
   input  logic                                          gameclk,
   input  logic                                          clr,
   input  logic                                          start,
   input  logic                                          pause_toggle,
   input  logic                                          move_tick,
   input  logic                                          score_tick,
   input  logic [$clog2(COLS)-1:0]                       plrpos,
   output logic [NUM_BARS*POS_W-1:0]                     barpos,
   output logic [NUM_BARS*$clog2(COLS-HOLE_W+1)-1:0]     holepos,
   output logic [LIFE_W-1:0]                             lives,
   output logic [TIME_W-1:0]                             timealive,
   output logic [2:0]                                    speed,
   output logic [1:0]                                    state,
   output logic                                          miss
);

   localparam int unsigned PW = $clog2(COLS);
   localparam int unsigned HW = $clog2(COLS - HOLE_W + 1);
   localparam int unsigned RW = $clog2(ROUNDS_PER_LEVEL + 1);

   localparam logic [HW-1:0]     HoleMax    = HW'(COLS - HOLE_W);
   localparam logic [HW-1:0]     HoleWrap   = HW'(COLS - HOLE_W + 1);
   localparam logic [HW-1:0]     HoleInit   = HW'(HOLE_RESET);
   localparam logic [POS_W-1:0]  CheckRow   = POS_W'(CHECK_ROW);
   localparam logic [POS_W-1:0]  ScreenEnd  = POS_W'(SCREEN_END);
   localparam logic [LIFE_W-1:0] LivesInit  = LIFE_W'(LIVES_INIT);
   localparam logic [2:0]        SpeedInit  = 3'(CYCLES_INIT);
   localparam logic [2:0]        SpeedMin   = 3'(CYCLES_MIN);
   localparam logic [RW-1:0]     RoundsLast = RW'(ROUNDS_PER_LEVEL - 1);
   localparam logic [15:0]       LfsrTaps   = 16'hB400;

   typedef enum logic [1:0] {
      StReady = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StOver  = 2'd3
   } state_e;

   function automatic logic [POS_W-1:0] bar_init(input int unsigned idx);
      return POS_W'((BAR_START + idx * BAR_SPACING) % (SCREEN_END + 1));
   endfunction

   // Widened compare so hole + HOLE_W - 1 cannot wrap.
   function automatic logic in_hole(input logic [HW-1:0] hole, input logic [PW-1:0] plr);
      logic [POS_W:0] lo;
      logic [POS_W:0] hi;
      logic [POS_W:0] p;
      lo = (POS_W+1)'(hole);
      hi = lo + (POS_W+1)'(HOLE_W - 1);
      p  = (POS_W+1)'(plr);
      return (p >= lo) && (p <= hi);
   endfunction

   state_e              state_q, state_d;
   logic [POS_W-1:0]    pos_q  [NUM_BARS];
   logic [POS_W-1:0]    pos_d  [NUM_BARS];
   logic [HW-1:0]       hole_q [NUM_BARS];
   logic [HW-1:0]       hole_d [NUM_BARS];
   logic [LIFE_W-1:0]   lives_q, lives_d;
   logic [TIME_W-1:0]   time_q, time_d;
   logic [2:0]          speed_q, speed_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [RW-1:0]       rounds_q, rounds_d;
   logic                miss_q, miss_d;
   logic [15:0]         lfsr_q, lfsr_d;
   logic [HW-1:0]       cand, new_hole;
   logic                do_step, crossed, missed;

   always_comb begin
      cand     = lfsr_q[HW-1:0];
      new_hole = (cand <= HoleMax) ? cand : cand - HoleWrap;
   end

   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      hole_d   = hole_q;
      lives_d  = lives_q;
      time_d   = time_q;
      speed_d  = speed_q;
      cnt_d    = cnt_q;
      rounds_d = rounds_q;
      miss_d   = 1'b0;
      lfsr_d   = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ LfsrTaps) : {1'b0, lfsr_q[15:1]};
      do_step  = 1'b0;
      crossed  = 1'b0;
      missed   = 1'b0;

      unique case (state_q)
         StReady: if (start) state_d = StRun;
         StOver: begin
            if (start) begin
               state_d = StRun;
               for (int unsigned i = 0; i < NUM_BARS; i++) begin
                  pos_d[i]  = bar_init(i);
                  hole_d[i] = HoleInit;
               end
               lives_d  = LivesInit;
               time_d   = '0;
               speed_d  = SpeedInit;
               cnt_d    = '0;
               rounds_d = '0;
            end
         end
         StPause: if (pause_toggle) state_d = StRun;
         StRun: begin
            if (score_tick && (time_q != '1)) time_d = time_q + 1'b1;
            // A pause request swallows a coincident move tick.
            if (pause_toggle) begin
               state_d = StPause;
            end else if (move_tick) begin
               if (({1'b0, cnt_q} + 4'd1) == {1'b0, speed_q}) begin
                  cnt_d   = '0;
                  do_step = 1'b1;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         default: state_d = StReady;
      endcase

      if (do_step) begin
         for (int unsigned i = 0; i < NUM_BARS; i++) begin
            if (pos_q[i] == CheckRow) begin
               crossed = 1'b1;
               if (!in_hole(hole_q[i], plrpos)) missed = 1'b1;
            end
            if (pos_q[i] == ScreenEnd) begin
               pos_d[i]  = '0;
               hole_d[i] = new_hole;
            end else begin
               pos_d[i] = pos_q[i] + 1'b1;
            end
         end
         if (missed) begin
            miss_d = 1'b1;
            if (lives_q != '0) lives_d = lives_q - 1'b1;
            if (lives_d == '0) state_d = StOver;
         end
         if (crossed) begin
            if (rounds_q == RoundsLast) begin
               rounds_d = '0;
               if (speed_q > SpeedMin) speed_d = speed_q - 3'd1;
            end else begin
               rounds_d = rounds_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge gameclk) begin
      if (clr) begin
         state_q <= StReady;
         for (int unsigned i = 0; i < NUM_BARS; i++) begin
            pos_q[i]  <= bar_init(i);
            hole_q[i] <= HoleInit;
         end
         lives_q  <= LivesInit;
         time_q   <= '0;
         speed_q  <= SpeedInit;
         cnt_q    <= '0;
         rounds_q <= '0;
         miss_q   <= 1'b0;
         lfsr_q   <= LFSR_SEED;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         hole_q   <= hole_d;
         lives_q  <= lives_d;
         time_q   <= time_d;
         speed_q  <= speed_d;
         cnt_q    <= cnt_d;
         rounds_q <= rounds_d;
         miss_q   <= miss_d;
         lfsr_q   <= lfsr_d;
      end
   end

   always_comb begin
      barpos  = '0;
      holepos = '0;
      for (int unsigned i = 0; i < NUM_BARS; i++) begin
         barpos[i*POS_W +: POS_W] = pos_q[i];
         holepos[i*HW +: HW]      = hole_q[i];
      end
   end

   assign lives     = lives_q;
   assign timealive = time_q;
   assign speed     = speed_q;
   assign state     = state_q;
   assign miss      = miss_q;

endmodule

// File: tb/tb_game_multibar.sv
// Bench for game_multibar: a behavioural game model feeds a scoreboard queue each cycle,
// and scenario tasks pop and compare, plus fixed-value checks at key points.
module tb_game_multibar;

   logic        gameclk;
   logic        clr, start, pause_toggle, move_tick, score_tick;
   logic [3:0]  plrpos;
   logic [17:0] barpos;
   logic [7:0]  holepos;
   logic [1:0]  lives;
   logic [15:0] timealive;
   logic [2:0]  speed;
   logic [1:0]  state;
   logic        miss;

   int n_total, n_bad;
   logic [49:0] sb[$];
   logic [49:0] exp_v;

   int          m_state, m_lives, m_time, m_speed, m_cnt, m_rounds;
   int          m_pos[2];
   int          m_hole[2];
   bit          m_miss;
   logic [15:0] m_lfsr;

   game_multibar dut (
      .gameclk      (gameclk),
      .clr          (clr),
      .start        (start),
      .pause_toggle (pause_toggle),
      .move_tick    (move_tick),
      .score_tick   (score_tick),
      .plrpos       (plrpos),
      .barpos       (barpos),
      .holepos      (holepos),
      .lives        (lives),
      .timealive    (timealive),
      .speed        (speed),
      .state        (state),
      .miss         (miss)
   );

   initial gameclk = 1'b0;
   always #5 gameclk = ~gameclk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", n_bad);
      $fatal(1);
   end

   function automatic logic [49:0] dut_obs();
      return {barpos, holepos, lives, timealive, speed, state, miss};
   endfunction

   function automatic logic [49:0] model_obs();
      return {9'(m_pos[1]), 9'(m_pos[0]), 4'(m_hole[1]), 4'(m_hole[0]), 2'(m_lives),
              16'(m_time), 3'(m_speed), 2'(m_state), m_miss};
   endfunction

   task automatic m_reinit();
      for (int b = 0; b < 2; b++) begin
         m_pos[b]  = (80 + b * 256) % 511;
         m_hole[b] = 7;
      end
      m_lives = 3; m_time = 0; m_speed = 7; m_cnt = 0; m_rounds = 0;
   endtask

   task automatic m_step(input logic [15:0] lf, input int plr);
      bit crossed, lost;
      int cand;
      crossed = 0; lost = 0;
      for (int b = 0; b < 2; b++) begin
         if (m_pos[b] == 440) begin
            crossed = 1;
            if (!(plr >= m_hole[b] && plr <= m_hole[b] + 2)) lost = 1;
         end
         if (m_pos[b] == 510) begin
            m_pos[b] = 0;
            cand = int'(lf[3:0]);
            m_hole[b] = (cand <= 13) ? cand : cand - 14;
         end else begin
            m_pos[b] = m_pos[b] + 1;
         end
      end
      if (lost) begin
         m_miss = 1;
         if (m_lives > 0) m_lives = m_lives - 1;
         if (m_lives == 0) m_state = 3;
      end
      if (crossed) begin
         m_rounds = m_rounds + 1;
         if (m_rounds == 3) begin
            m_rounds = 0;
            if (m_speed > 1) m_speed = m_speed - 1;
         end
      end
   endtask

   task automatic m_update(input bit c, input bit s, input bit p, input bit mt, input bit sc,
                           input int plr);
      logic [15:0] old;
      if (c) begin
         m_reinit();
         m_state = 0; m_miss = 0; m_lfsr = 16'hACE1;
         return;
      end
      old    = m_lfsr;
      m_lfsr = old[0] ? ((old >> 1) ^ 16'hB400) : (old >> 1);
      m_miss = 0;
      case (m_state)
         0: if (s) m_state = 1;
         3: if (s) begin m_reinit(); m_state = 1; end
         2: if (p) m_state = 1;
         default: begin
            if (sc && m_time < 65535) m_time = m_time + 1;
            if (p) m_state = 2;
            else if (mt) begin
               m_cnt = m_cnt + 1;
               if (m_cnt == m_speed) begin
                  m_cnt = 0;
                  m_step(old, plr);
               end
            end
         end
      endcase
   endtask

   // Drive one cycle of inputs, push the model's expectation, and land #1 after the edge.
   task automatic drive(input bit c, input bit s, input bit p, input bit mt, input bit sc,
                        input int plr);
      clr = c; start = s; pause_toggle = p; move_tick = mt; score_tick = sc;
      plrpos = 4'(plr);
      m_update(c, s, p, mt, sc, plr);
      sb.push_back(model_obs());
      @(posedge gameclk);
      #1;
   endtask

   function automatic int track_hit();
      int pl;
      pl = 8;
      for (int b = 0; b < 2; b++) if (m_pos[b] == 440) pl = m_hole[b];
      return pl;
   endfunction

   function automatic int track_miss();
      int pl;
      pl = 8;
      for (int b = 0; b < 2; b++) if (m_pos[b] == 440) pl = (m_hole[b] >= 3) ? 0 : 15;
      return pl;
   endfunction

   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         drive(1, 0, 0, 0, 0, 0);
         exp_v = sb.pop_front(); n_total++;
         if (dut_obs() !== exp_v) begin
            n_bad++; $display("FAIL reset_sb: got %h want %h", dut_obs(), exp_v);
         end
      end
      n_total++;
      if (barpos !== {9'd336, 9'd80}) begin
         n_bad++; $display("FAIL reset_barpos: got %h want %h", barpos, {9'd336, 9'd80});
      end
      n_total++;
      if (holepos !== 8'h77) begin
         n_bad++; $display("FAIL reset_holepos: got %h want 77", holepos);
      end
      n_total++;
      if ({lives, timealive, speed, state, miss} !== {2'd3, 16'd0, 3'd7, 2'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_misc: got l=%0d t=%0d s=%0d st=%0d m=%0d want 3 0 7 0 0",
                  lives, timealive, speed, state, miss);
      end
      for (int k = 0; k < 10; k++) begin
         drive(0, 0, 0, 1, 1, 5);
         exp_v = sb.pop_front(); n_total++;
         if (dut_obs() !== exp_v) begin
            n_bad++; $display("FAIL ready_sb: got %h want %h", dut_obs(), exp_v);
         end
      end
      n_total++;
      if (barpos !== {9'd336, 9'd80}) begin
         n_bad++; $display("FAIL ready_hold: got %h want %h", barpos, {9'd336, 9'd80});
      end
   endtask

   task automatic test_step();
      drive(0, 1, 0, 0, 0, 5);
      exp_v = sb.pop_front(); n_total++;
      if (dut_obs() !== exp_v) begin
         n_bad++; $display("FAIL start_sb: got %h want %h", dut_obs(), exp_v);
      end
      n_total++;
      if (state !== 2'd1) begin n_bad++; $display("FAIL start_state: got %0d want 1", state); end
      for (int k = 0; k < 6; k++) begin
         drive(0, 0, 0, 1, 0, 5);
         exp_v = sb.pop_front(); n_total++;
         if (dut_obs() !== exp_v) begin
            n_bad++; $display("FAIL step_sb: got %h want %h", dut_obs(), exp_v);
         end
      end
      n_total++;
      if (barpos !== {9'd336, 9'd80}) begin
         n_bad++; $display("FAIL step_tick6: got %h want %h", barpos, {9'd336, 9'd80});
      end
      drive(0, 0, 0, 1, 0, 5);
      exp_v = sb.pop_front(); n_total++;
      if (dut_obs() !== exp_v) begin
         n_bad++; $display("FAIL step_sb: got %h want %h", dut_obs(), exp_v);
      end
      n_total++;
      if (barpos !== {9'd337, 9'd81}) begin
         n_bad++; $display("FAIL step_tick7: got %h want %h", barpos, {9'd337, 9'd81});
      end
   endtask

   task automatic test_hit_miss();
      int k;
      for (k = 0; k < 2000 && m_pos[1] != 441; k++) begin
         drive(0, 0, 0, 1, 0, 8);
         exp_v = sb.pop_front(); n_total++;
         if (dut_obs() !== exp_v) begin
            n_bad++; $display("FAIL hit_sb: got %h want %h", dut_obs(), exp_v);
         end
      end
      if (m_pos[1] != 441) begin
         n_total++; n_bad++; $display("FAIL hit_timeout: got %0d want 441", m_pos[1]);
      end
      n_total++;
      if (lives !== 2'd3) begin n_bad++; $display("FAIL hit_lives: got %0d want 3", lives); end
      for (k = 0; k < 3000 && m_pos[0] != 441; k++) begin
         drive(0, 0, 0, 1, 0, 3);
         exp_v = sb.pop_front(); n_total++;
         if (dut_obs() !== exp_v) begin
            n_bad++; $display("FAIL miss_sb: got %h want %h", dut_obs(), exp_v);
         end
      end
      if (m_pos[0] != 441) begin
         n_total++; n_bad++; $display("FAIL miss_timeout: got %0d want 441", m_pos[0]);
      end
      n_total++;
      if ({lives, miss} !== {2'd2, 1'b1}) begin
         n_bad++; $display("FAIL miss_pulse: got l=%0d m=%0d want l=2 m=1", lives, miss);
      end
      drive(0, 0, 0, 0, 0, 3);
      exp_v = sb.pop_front(); n_total++;
      if (dut_obs() !== exp_v) begin
         n_bad++; $display("FAIL miss_sb: got %h want %h", dut_obs(), exp_v);
      end
      n_total++;
      if (miss !== 1'b0) begin n_bad++; $display("FAIL miss_width: got %0d want 0", miss); end
   endtask

   task automatic speed_loop(input int limit, input int target, input int fixed);
      int pre[2];
      for (int k = 0; k < limit && (fixed > 0 || m_speed != target); k++) begin
         if (fixed > 0 && k >= fixed) break;
         pre[0] = m_pos[0]; pre[1] = m_pos[1];
         drive(0, 0, 0, 1, 1'($urandom_range(0, 1)), track_hit());
         exp_v = sb.pop_front(); n_total++;
         if (dut_obs() !== exp_v) begin
            n_bad++; $display("FAIL speed_sb: got %h want %h", dut_obs(), exp_v);
         end
         for (int b = 0; b < 2; b++) begin
            if (pre[b] == 510 && m_pos[b] == 0) begin
               n_total++;
               if (barpos[b*9 +: 9] !== 9'd0 || holepos[b*4 +: 4] > 4'd13) begin
                  n_bad++;
                  $display("FAIL wrap_bar%0d: got pos=%0d hole=%0d want pos=0 hole<=13",
                           b, barpos[b*9 +: 9], holepos[b*4 +: 4]);
               end
            end
         end
      end
   endtask

   task automatic test_speed();
      speed_loop(4000, 6, 0);
      n_total++;
      if (speed !== 3'd6) begin n_bad++; $display("FAIL speed_first: got %0d want 6", speed); end
      speed_loop(30000, 1, 0);
      n_total++;
      if (speed !== 3'd1) begin n_bad++; $display("FAIL speed_min: got %0d want 1", speed); end
      speed_loop(1800, 1, 1800);
      n_total++;
      if ({speed, lives} !== {3'd1, 2'd2}) begin
         n_bad++; $display("FAIL speed_floor: got s=%0d l=%0d want s=1 l=2", speed, lives);
      end
   endtask

   task automatic test_over();
      logic [17:0] fb;
      logic [15:0] ft;
      int k;
      for (k = 0; k < 3000 && m_state != 3; k++) begin
         drive(0, 0, 0, 1, 1, track_miss());
         exp_v = sb.pop_front(); n_total++;
         if (dut_obs() !== exp_v) begin
            n_bad++; $display("FAIL over_sb: got %h want %h", dut_obs(), exp_v);
         end
      end
      n_total++;
      if ({lives, state} !== {2'd0, 2'd3}) begin
         n_bad++; $display("FAIL over_enter: got l=%0d st=%0d want l=0 st=3", lives, state);
      end
      fb = {9'(m_pos[1]), 9'(m_pos[0])};
      ft = 16'(m_time);
      for (k = 0; k < 20; k++) begin
         drive(0, 0, 1'(k % 2), 1, 1, 8);
         exp_v = sb.pop_front(); n_total++;
         if (dut_obs() !== exp_v) begin
            n_bad++; $display("FAIL over_sb: got %h want %h", dut_obs(), exp_v);
         end
      end
      n_total++;
      if ({barpos, timealive} !== {fb, ft}) begin
         n_bad++; $display("FAIL over_freeze: got %h/%0d want %h/%0d", barpos, timealive, fb, ft);
      end
      drive(0, 1, 1, 0, 0, 8);
      exp_v = sb.pop_front(); n_total++;
      if (dut_obs() !== exp_v) begin
         n_bad++; $display("FAIL restart_sb: got %h want %h", dut_obs(), exp_v);
      end
      n_total++;
      if ({state, lives, speed, barpos, timealive} !==
          {2'd1, 2'd3, 3'd7, 9'd336, 9'd80, 16'd0}) begin
         n_bad++;
         $display("FAIL restart_vals: got st=%0d l=%0d s=%0d bar=%h t=%0d want 1 3 7 %h 0",
                  state, lives, speed, barpos, timealive, {9'd336, 9'd80});
      end
   endtask

   task automatic test_pause();
      int t;
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 1, 0, 8);
         exp_v = sb.pop_front(); n_total++;
         if (dut_obs() !== exp_v) begin
            n_bad++; $display("FAIL pause_sb: got %h want %h", dut_obs(), exp_v);
         end
      end
      drive(0, 0, 1, 1, 1, 8);
      exp_v = sb.pop_front(); n_total++;
      if (dut_obs() !== exp_v) begin
         n_bad++; $display("FAIL pause_sb: got %h want %h", dut_obs(), exp_v);
      end
      n_total++;
      if ({state, barpos} !== {2'd2, 9'd336, 9'd80}) begin
         n_bad++; $display("FAIL pause_enter: got st=%0d bar=%h want 2 %h", state, barpos,
                           {9'd336, 9'd80});
      end
      t = m_time;
      for (int k = 0; k < 20; k++) begin
         drive(0, 0, 0, 1'(k % 2), 1, 8);
         exp_v = sb.pop_front(); n_total++;
         if (dut_obs() !== exp_v) begin
            n_bad++; $display("FAIL pause_sb: got %h want %h", dut_obs(), exp_v);
         end
      end
      n_total++;
      if (timealive !== 16'(t)) begin
         n_bad++; $display("FAIL pause_score: got %0d want %0d", timealive, t);
      end
      drive(0, 0, 1, 0, 0, 8);
      exp_v = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 1, 0, 8);
         exp_v = sb.pop_front(); n_total++;
         if (dut_obs() !== exp_v) begin
            n_bad++; $display("FAIL resume_sb: got %h want %h", dut_obs(), exp_v);
         end
      end
      n_total++;
      if ({state, barpos} !== {2'd1, 9'd336, 9'd80}) begin
         n_bad++; $display("FAIL resume_hold: got st=%0d bar=%h", state, barpos);
      end
      drive(0, 0, 0, 1, 0, 8);
      exp_v = sb.pop_front(); n_total++;
      if (barpos !== {9'd337, 9'd81}) begin
         n_bad++; $display("FAIL resume_step: got %h want %h", barpos, {9'd337, 9'd81});
      end
      for (int k = 0; k < 6; k++) begin
         drive(0, 0, 0, 1, 1, 8);
         exp_v = sb.pop_front();
      end
      drive(1, 0, 0, 1, 1, 8);
      exp_v = sb.pop_front(); n_total++;
      if ({state, barpos} !== {2'd0, 9'd336, 9'd80}) begin
         n_bad++; $display("FAIL clr_midstep: got st=%0d bar=%h want 0 %h", state, barpos,
                           {9'd336, 9'd80});
      end
      drive(0, 1, 0, 0, 0, 8);
      exp_v = sb.pop_front();
      drive(0, 0, 0, 1, 1, 8);
      exp_v = sb.pop_front();
      drive(0, 0, 1, 0, 0, 8);
      exp_v = sb.pop_front(); n_total++;
      if (dut_obs() !== exp_v) begin
         n_bad++; $display("FAIL pause2_sb: got %h want %h", dut_obs(), exp_v);
      end
      drive(1, 0, 1, 1, 1, 8);
      exp_v = sb.pop_front(); n_total++;
      if (dut_obs() !== {9'd336, 9'd80, 8'h77, 2'd3, 16'd0, 3'd7, 2'd0, 1'b0}) begin
         n_bad++; $display("FAIL clr_pause: got %h want %h", dut_obs(),
                           {9'd336, 9'd80, 8'h77, 2'd3, 16'd0, 3'd7, 2'd0, 1'b0});
      end
      drive(0, 1, 1, 0, 0, 8);
      exp_v = sb.pop_front(); n_total++;
      if (state !== 2'd1) begin
         n_bad++; $display("FAIL start_beats_pause: got %0d want 1", state);
      end
   endtask

   initial begin
      clr = 1'b0; start = 1'b0; pause_toggle = 1'b0; move_tick = 1'b0; score_tick = 1'b0;
      plrpos = 4'd0;
      n_total = 0; n_bad = 0;
      @(posedge gameclk);
      #1;
      test_reset();
      test_step();
      test_hit_miss();
      test_speed();
      test_over();
      test_pause();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/game_multibar.md
Name: game_multibar

Overview:
- Parametrised next-generation game engine for the falling-bar game: N bars scroll down the screen; each bar has a hole of HOLE_W columns that the player must sit in when the bar crosses the check row.
- Adds over the previous game core: multiple concurrent bars, a start/pause/game-over FSM, an internal LFSR for hole placement, a configurable speed-up schedule and a miss strobe.
- Single clock domain. Former separate clocks become one-cycle enable strobes from the clock divider. Outputs drive the VGA renderer and the score display.

Parameters:
- NUM_BARS, 2, number of concurrent bars
- POS_W, 9, bar position width
- BAR_START, 80, reset position of bar 0
- BAR_SPACING, 256, reset offset between bars; bar i resets to (BAR_START + i*BAR_SPACING) mod (SCREEN_END+1)
- SCREEN_END, 510, last position before wrap
- CHECK_ROW, 440, position at which hole/player collision is evaluated
- COLS, 16, player column count
- HOLE_W, 3, hole width in columns
- HOLE_RESET, 7, hole position of every bar after reset/restart
- LIFE_W, 2, lives width
- LIVES_INIT, 3, starting lives
- CYCLES_INIT, 7, initial move_ticks per bar step
- CYCLES_MIN, 1, fastest allowed step divisor
- ROUNDS_PER_LEVEL, 3, check-row crossings per speed-up
- TIME_W, 16, score counter width
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
- gameclk  in  1  system clock
- clr  in  1  synchronous active-high reset
- start  in  1  start/restart request, level-sampled
- pause_toggle  in  1  one-cycle pulse; toggles RUN/PAUSE
- move_tick  in  1  one-cycle game-step enable
- score_tick  in  1  one-cycle score enable
- plrpos  in  clog2(COLS)  player column
- barpos  out  NUM_BARS*POS_W  packed bar positions, bar 0 in LSBs
- holepos  out  NUM_BARS*HW  packed hole positions, HW=clog2(COLS-HOLE_W+1)
- lives  out  LIFE_W  remaining lives
- timealive  out  TIME_W  survival score
- speed  out  3  current cycles-per-step value
- state  out  2  READY=0, RUN=1, PAUSE=2, OVER=3
- miss  out  1  one-cycle pulse, registered, when a life is lost

Behaviour:
- Reset (clr=1 on a gameclk edge; dominates all other inputs):
  - state=READY; bar i at its reset position; every hole=HOLE_RESET.
  - lives=LIVES_INIT, timealive=0, speed=CYCLES_INIT, cycle counter=0, rounds=0, miss=0, LFSR=LFSR_SEED.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Advances every clock in all states except reset.
  - HOLE_MAX=COLS-HOLE_W. cand = LFSR[HW-1:0].
  - New hole = cand if cand<=HOLE_MAX, else cand-(HOLE_MAX+1).
- FSM transitions:
  - READY: start -> RUN.
  - RUN: pause_toggle -> PAUSE; lives reaching 0 -> OVER.
  - PAUSE: pause_toggle -> RUN.
  - OVER: start -> RUN, reinitialising all reset values except the LFSR.
  - start and pause_toggle in the same cycle in READY/OVER: start wins.
  - pause_toggle in the same cycle as move_tick in RUN: enter PAUSE and ignore the tick.
- Stepping (RUN only): each move_tick increments the counter. When counter+1==speed, clear the counter and step all bars in that cycle. Outputs update on that same edge, i.e. 1-cycle latency from the qualifying tick.
- Per bar, per step:
  - If pos==CHECK_ROW: hit iff hole <= plrpos <= hole+HOLE_W-1, compared at POS_W+1 bits with no overflow. A miss decrements lives (saturating at 0) and pulses miss. Every crossing increments rounds.
  - If pos==SCREEN_END: next pos=0 and the hole reloads from the LFSR. Otherwise pos+1.
- Only one bar can sit at CHECK_ROW in a step, because reset positions are distinct and bars move in lockstep.
- Speed-up: when rounds+1 reaches ROUNDS_PER_LEVEL, rounds=0. If speed>CYCLES_MIN then speed-1. The new speed applies from the next tick.
- Last life lost: lives=0 and state=OVER on the same edge. In OVER, bars, holes, speed and timealive freeze.
- Score: timealive increments on score_tick only in RUN and saturates at all-ones. It holds in READY/PAUSE/OVER.
- Ticks outside RUN are ignored and the cycle counter holds. Reset mid-step discards the step.

Test Plan:
- Reset with defaults -> barpos={336,80}, holepos={7,7}, lives=3, timealive=0, speed=7, state=READY, miss=0. move_ticks in READY leave barpos unchanged.
- start, then 7 move_ticks -> after the 7th tick barpos={337,81}. The 6th tick gives no change.
- plrpos=8 while bar 1 crosses 440 -> lives stay 3. Repeat with plrpos=3 -> lives=2 and miss high for exactly 1 cycle.
- Three check-row crossings -> speed 7->6; continue to speed=1 and confirm it never goes below 1. Bar at 510 steps to 0 with holepos in 0..13.
- Three misses -> lives=0, state=OVER, barpos and timealive frozen under further ticks. start -> RUN with lives=3, speed=7, bars at reset positions.
- Pause with concurrent move_tick -> PAUSE, no step; 20 score_ticks leave timealive unchanged. Toggle back -> RUN resumes from the held counter. clr asserted in PAUSE -> READY with all reset values.
